// File: rtl/lcd_write_engine.sv
// HD44780-style LCD write strobe generator: latches one byte, then sequences
// setup, enable pulse and hold timing, and handshakes completion with the host.
module lcd_write_engine #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PW    = 12,
  parameter int unsigned T_HOLD  = 2
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iSTART,
  output logic       oDONE,
  output logic       oBUSY,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PW_LAST    = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      rs_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next state; each phase ends when the counter reaches its last cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    en_d    = en_q;
    data_d  = data_q;
    rs_d    = rs_q;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (iSTART) begin
          state_d = S_SETUP;
          data_d  = iDATA;
          rs_d    = iRS;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == PW_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        cnt_d = '0;
        // Wait for the host to drop its request so a held iSTART cannot re-fire
        if (!iSTART) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        en_d    = 1'b0;
        done_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign oDONE    = done_q;
  assign oBUSY    = busy_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_EN   = en_q;
  assign LCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: default-timing and minimum-timing instances run
// side by side against a write-timeline reference model.
module tb_lcd_write_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       irs = 1'b0;
  logic [7:0] idata = 8'h00;

  logic       done_a, busy_a, rs_a, rw_a, en_a;
  logic [7:0] data_a;
  logic       done_b, busy_b, rs_b, rw_b, en_b;
  logic [7:0] data_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  lcd_write_engine dut_a (
    .iCLK(clk), .iRST(rst), .iDATA(idata), .iRS(irs), .iSTART(start),
    .oDONE(done_a), .oBUSY(busy_a), .LCD_DATA(data_a), .LCD_RS(rs_a),
    .LCD_RW(rw_a), .LCD_EN(en_a)
  );

  lcd_write_engine #(.T_SETUP(1), .T_PW(1), .T_HOLD(1)) dut_b (
    .iCLK(clk), .iRST(rst), .iDATA(idata), .iRS(irs), .iSTART(start),
    .oDONE(done_b), .oBUSY(busy_b), .LCD_DATA(data_b), .LCD_RS(rs_b),
    .LCD_RW(rw_b), .LCD_EN(en_b)
  );

  wire [12:0] obs_a = {en_a, done_a, busy_a, rs_a, rw_a, data_a};
  wire [12:0] obs_b = {en_b, done_b, busy_b, rs_b, rw_b, data_b};

  // Reference model: a write is a timeline measured from its start edge E0
  int         m_ts[2] = '{2, 1};
  int         m_pw[2] = '{12, 1};
  int         m_hd[2] = '{2, 1};
  logic       m_act[2] = '{1'b0, 1'b0};
  int         m_e0[2] = '{0, 0};
  logic [7:0] m_data[2] = '{8'h00, 8'h00};
  logic       m_rs[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k]  <= 1'b0;
        m_data[k] <= 8'h00;
        m_rs[k]   <= 1'b0;
      end else if (!m_act[k]) begin
        if (start) begin
          m_act[k]  <= 1'b1;
          m_e0[k]   <= cyc;
          m_data[k] <= idata;
          m_rs[k]   <= irs;
        end
      end else if ((cyc - m_e0[k]) > (m_ts[k] + m_pw[k] + m_hd[k]) && !start) begin
        m_act[k] <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  function automatic logic [12:0] model_out(int k);
    int   t;
    logic en, dn;
    t  = (cyc - 1) - m_e0[k];
    en = m_act[k] && (t >= m_ts[k]) && (t < m_ts[k] + m_pw[k]);
    dn = m_act[k] && (t >= m_ts[k] + m_pw[k] + m_hd[k]);
    return {en, dn, m_act[k], m_rs[k], 1'b0, m_data[k]};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    idata = 8'hA5;
    irs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== 26'd0) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%h exp=0", cyc, {obs_a, obs_b});
      end
    end
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({obs_a, obs_b} !== {model_out(0), model_out(1)}) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", {obs_a, obs_b}, {model_out(0), model_out(1)});
    end
  endtask

  // Held iSTART: one pulse, EN high samples 2..13, oDONE from 16
  task automatic test_default_write();
    int en_cnt, rises, first_en, first_done;
    logic prev_en;
    en_cnt = 0; rises = 0; first_en = -1; first_done = -1; prev_en = 1'b0;
    idata = 8'h38;
    irs = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {model_out(0), model_out(1)}) begin
        failures++;
        $display("FAIL default_write i=%0d got=%h exp=%h", i, {obs_a, obs_b}, {model_out(0), model_out(1)});
      end
      if (en_a) en_cnt++;
      if (en_a && !prev_en) rises++;
      if (en_a && first_en < 0) first_en = i;
      if (done_a && first_done < 0) first_done = i;
      prev_en = en_a;
    end
    checks++;
    if (en_cnt != 12 || rises != 1 || first_en != 2 || first_done != 16 || data_a !== 8'h38) begin
      failures++;
      $display("FAIL default_timing got en=%0d rises=%0d first_en=%0d done_at=%0d data=%h exp 12/1/2/16/38",
               en_cnt, rises, first_en, first_done, data_a);
    end
  endtask

  // Drop iSTART for one cycle from DONE, then a second write
  task automatic test_back_to_back();
    int idle_cnt;
    idle_cnt = 0;
    for (int i = 0; i < 22; i++) begin
      start = (i != 0);
      idata = (i == 0) ? 8'hFF : 8'h41;
      irs = (i != 0);
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {model_out(0), model_out(1)}) begin
        failures++;
        $display("FAIL back_to_back i=%0d got=%h exp=%h", i, {obs_a, obs_b}, {model_out(0), model_out(1)});
      end
      if (!busy_a) idle_cnt++;
    end
    checks++;
    if (idle_cnt != 1 || data_a !== 8'h41 || rs_a !== 1'b1 || done_a !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_sum got idle=%0d data=%h rs=%b done=%b exp 1/41/1/1",
               idle_cnt, data_a, rs_a, done_a);
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Input bus toggles during the write must not reach LCD_DATA
  task automatic test_data_toggle();
    logic [7:0] latched;
    latched = 8'($urandom);
    idata = latched;
    irs = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      idata = ~idata ^ 8'($urandom);
      irs = ~irs;
      checks++;
      if ({obs_a, obs_b} !== {model_out(0), model_out(1)} || data_a !== latched) begin
        failures++;
        $display("FAIL data_toggle i=%0d got=%h exp=%h latched=%h", i, {obs_a, obs_b},
                 {model_out(0), model_out(1)}, latched);
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One-cycle reset mid-pulse aborts; iSTART held through reset starts afresh
  task automatic test_reset_mid_pulse();
    logic saw_done;
    saw_done = 1'b0;
    idata = 8'h0C;
    irs = 1'b0;
    start = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (en_a !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_en got=%b exp=1", en_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({obs_a, obs_b} !== 26'd0) begin
      failures++;
      $display("FAIL reset_mid_pulse got=%h exp=0", {obs_a, obs_b});
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_a) saw_done = 1'b1;
      checks++;
      if ({obs_a, obs_b} !== {model_out(0), model_out(1)}) begin
        failures++;
        $display("FAIL after_reset i=%0d got=%h exp=%h", i, {obs_a, obs_b}, {model_out(0), model_out(1)});
      end
    end
    checks++;
    if (!saw_done) begin
      failures++;
      $display("FAIL after_reset_done got=0 exp=1");
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One-cycle iSTART pulse; minimum-timing instance checked explicitly
  task automatic test_fast_pulse();
    logic [19:0] en_seq, done_seq;
    en_seq = '0;
    done_seq = '0;
    idata = 8'h01;
    irs = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      en_seq[i] = en_b;
      done_seq[i] = done_b;
      checks++;
      if ({obs_a, obs_b} !== {model_out(0), model_out(1)}) begin
        failures++;
        $display("FAIL fast_pulse i=%0d got=%h exp=%h", i, {obs_a, obs_b}, {model_out(0), model_out(1)});
      end
    end
    checks++;
    if (en_seq !== 20'h00002 || done_seq !== 20'h00008 || busy_b !== 1'b0) begin
      failures++;
      $display("FAIL fast_timing got en=%h done=%h busy=%b exp 00002/00008/0", en_seq, done_seq, busy_b);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 3) != 0);
      idata = 8'($urandom);
      irs = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({obs_a, obs_b} !== {model_out(0), model_out(1)}) begin
        failures++;
        $display("FAIL random i=%0d got=%h exp=%h", i, {obs_a, obs_b}, {model_out(0), model_out(1)});
      end
    end
    rst = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_write();
    test_back_to_back();
    test_data_toggle();
    test_reset_mid_pulse();
    test_fast_pulse();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
